seg_scan_decoder: RTL and testbench

Receive-side monitor for the multiplexed 4-digit 7-segment drive. It samples the display driver's `sm_wei`/`sm_duan` outputs once per scan clock and decodes each segment pattern back to a hex nibble plus decimal point. It reassembles complete 4-digit frames into a 16-bit value and flags malformed scans. It is used for display loopback self-test and as a scoreboard front-end in the stopwatch benches.

---
 rtl/seg_scan_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a multiplexed 4-digit 7-segment scan: decodes digits, reassembles frames, flags bad scans.
// Optional SEG_SCAN_STABLE_FILTER_EN: publish only after STABLE_FRAMES identical consecutive good frames.
module seg_scan_decoder #(
    parameter bit          WEI_ACTIVE_LOW  = 1'b1,
    parameter bit          DUAN_ACTIVE_LOW = 1'b1,
    parameter int unsigned TIMEOUT         = 16,
    parameter int unsigned STABLE_FRAMES   = 3
) (
    input  logic        clk_200Hz,
    input  logic        rst,
    input  logic [3:0]  sm_wei,
    input  logic [7:0]  sm_duan,
    output logic [15:0] data_out,
    output logic [3:0]  dot_out,
    output logic        frame_valid,
    output logic        stable,
    output logic        seg_err,
    output logic        seq_err,
    output logic        scan_lost
);

    typedef enum logic {HUNT, COLLECT} state_t;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("seg_scan_decoder: TIMEOUT out of range 2..255");
    end
    if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15) begin : g_bad_stable
        $error("seg_scan_decoder: STABLE_FRAMES out of range 1..15");
    end

    logic [3:0]  wei_reg;
    logic [7:0]  duan_reg;
    state_t      state_reg;
    logic [3:0]  mask_reg;
    logic [3:0]  prev_reg;
    logic        bad_reg;
    logic [7:0]  cnt_reg;
    logic [15:0] digits_reg;
    logic [3:0]  dots_reg;

    logic [15:0] seg_match;
    logic [3:0]  nibble;
    logic        seg_ok;
    logic        sample_valid;
    logic        seen_hit;
    logic        same_prev;
    logic        new_bit;
    logic        revisit;
    logic        progress;
    logic        closes;
    logic        timeout_hit;
    logic        frame_good;
    logic [3:0]  mask_set;
    logic [7:0]  cnt_inc;
    logic [15:0] digits_merge;
    logic [3:0]  dots_merge;

    for (genvar gi = 0; gi < 16; gi++) begin : g_match
        assign seg_match[gi] = (duan_reg[6:0] == SEG_TABLE[gi]);
    end

    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_match[i]) nibble = 4'(i);
        end
    end

    // Current sample merged into the stored digits; only meaningful for a one-hot select
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign digits_merge[gi*4 +: 4] = wei_reg[gi] ? nibble : digits_reg[gi*4 +: 4];
        assign dots_merge[gi]          = wei_reg[gi] ? duan_reg[7] : dots_reg[gi];
    end

    assign seg_ok       = |seg_match;
    assign sample_valid = $onehot(wei_reg);
    assign seen_hit     = |(mask_reg & wei_reg);
    assign same_prev    = (wei_reg == prev_reg);
    assign new_bit      = sample_valid && !seen_hit;
    assign revisit      = sample_valid && seen_hit && !same_prev;
    assign progress     = new_bit || revisit;
    assign mask_set     = mask_reg | wei_reg;
    assign closes       = new_bit && (mask_set == 4'hF);
    assign frame_good   = closes && !bad_reg && seg_ok;
    assign cnt_inc      = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
    // Only non-progressing cycles can expire the scan, so timeout wins over junk samples
    assign timeout_hit  = (state_reg == COLLECT) && !progress && (cnt_reg >= 8'(TIMEOUT - 1));

`ifdef SEG_SCAN_STABLE_FILTER_EN
    logic [15:0] last_data_reg;
    logic [3:0]  last_dot_reg;
    logic        last_ok_reg;
    logic [3:0]  run_reg;
`endif

    always_ff @(posedge clk_200Hz) begin
        if (rst) begin
            wei_reg     <= 4'h0;
            duan_reg    <= 8'h00;
            state_reg   <= HUNT;
            mask_reg    <= 4'h0;
            prev_reg    <= 4'h0;
            bad_reg     <= 1'b0;
            cnt_reg     <= 8'h00;
            digits_reg  <= 16'h0000;
            dots_reg    <= 4'h0;
            data_out    <= 16'h0000;
            dot_out     <= 4'h0;
            frame_valid <= 1'b0;
            stable      <= 1'b0;
            seg_err     <= 1'b0;
            seq_err     <= 1'b0;
            scan_lost   <= 1'b0;
`ifdef SEG_SCAN_STABLE_FILTER_EN
            last_data_reg <= 16'h0000;
            last_dot_reg  <= 4'h0;
            last_ok_reg   <= 1'b0;
            run_reg       <= 4'h0;
`endif
        end else begin
            wei_reg     <= sm_wei ^ {4{WEI_ACTIVE_LOW}};
            duan_reg    <= sm_duan ^ {8{DUAN_ACTIVE_LOW}};
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            seq_err     <= 1'b0;
            case (state_reg)
                HUNT: begin
                    if (sample_valid) begin
                        state_reg  <= COLLECT;
                        scan_lost  <= 1'b0;
                        cnt_reg    <= 8'h00;
                        mask_reg   <= wei_reg;
                        prev_reg   <= wei_reg;
                        bad_reg    <= !seg_ok;
                        seg_err    <= !seg_ok;
                        digits_reg <= digits_merge;
                        dots_reg   <= dots_merge;
                    end
                end
                default: begin
                    if (timeout_hit) begin
                        state_reg <= HUNT;
                        scan_lost <= 1'b1;
                        stable    <= 1'b0;
                        mask_reg  <= 4'h0;
                        bad_reg   <= 1'b0;
                        cnt_reg   <= 8'h00;
                    end else if (sample_valid) begin
                        seg_err    <= !seg_ok;
                        prev_reg   <= wei_reg;
                        digits_reg <= digits_merge;
                        dots_reg   <= dots_merge;
                        if (new_bit) begin
                            cnt_reg <= 8'h00;
                            if (closes) begin
                                mask_reg <= 4'h0;
                                bad_reg  <= 1'b0;
                            end else begin
                                mask_reg <= mask_set;
                                bad_reg  <= bad_reg | !seg_ok;
                            end
                        end else if (revisit) begin
                            seq_err  <= 1'b1;
                            cnt_reg  <= 8'h00;
                            mask_reg <= wei_reg;
                            bad_reg  <= !seg_ok;
                        end else begin
                            cnt_reg <= cnt_inc;
                            bad_reg <= bad_reg | !seg_ok;
                        end
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
            endcase

            if (frame_good && state_reg == COLLECT && !timeout_hit) begin
`ifdef SEG_SCAN_STABLE_FILTER_EN
                if (last_ok_reg && digits_merge == last_data_reg && dots_merge == last_dot_reg) begin
                    if (run_reg != 4'hF) run_reg <= run_reg + 4'd1;
                    if ({1'b0, run_reg} + 5'd1 == 5'(STABLE_FRAMES)) begin
                        data_out    <= digits_merge;
                        dot_out     <= dots_merge;
                        frame_valid <= 1'b1;
                        stable      <= 1'b1;
                    end
                end else begin
                    run_reg       <= 4'd1;
                    last_data_reg <= digits_merge;
                    last_dot_reg  <= dots_merge;
                    last_ok_reg   <= 1'b1;
                    if (STABLE_FRAMES == 1) begin
                        data_out    <= digits_merge;
                        dot_out     <= dots_merge;
                        frame_valid <= 1'b1;
                        stable      <= 1'b1;
                    end else begin
                        stable <= 1'b0;
                    end
                end
`else
                data_out    <= digits_merge;
                dot_out     <= dots_merge;
                frame_valid <= 1'b1;
                stable      <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scan scenarios then random scans, compared every cycle
// against a frame-level reference model (honours SEG_SCAN_STABLE_FILTER_EN when defined).
module tb_seg_scan_decoder;

    localparam int TIMEOUT       = 16;
    localparam int STABLE_FRAMES = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sm_wei = 4'hF;
    logic [7:0]  sm_duan = 8'hFF;
    logic [15:0] data_out;
    logic [3:0]  dot_out;
    logic        frame_valid, stable, seg_err, seq_err, scan_lost;

    seg_scan_decoder #(
        .WEI_ACTIVE_LOW (1'b1),
        .DUAN_ACTIVE_LOW(1'b1),
        .TIMEOUT        (TIMEOUT),
        .STABLE_FRAMES  (STABLE_FRAMES)
    ) dut (
        .clk_200Hz  (clk),
        .rst        (rst),
        .sm_wei     (sm_wei),
        .sm_duan    (sm_duan),
        .data_out   (data_out),
        .dot_out    (dot_out),
        .frame_valid(frame_valid),
        .stable     (stable),
        .seg_err    (seg_err),
        .seq_err    (seq_err),
        .scan_lost  (scan_lost)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int frames = 0;

    logic [6:0] seg_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference model state
    bit          m_hunt;
    bit          m_seen [4];
    int          m_prev;
    bit          m_bad;
    int          m_cnt;
    logic [3:0]  m_dig [4];
    logic        m_dot [4];
    logic [15:0] m_data;
    logic [3:0]  m_dots;
    logic        m_fv, m_stable, m_se, m_qe, m_lost;
    logic [15:0] m_last_data;
    logic [3:0]  m_last_dot;
    bit          m_last_ok;
    int          m_run;
    logic [3:0]  pw;
    logic [7:0]  pd;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hunt = 1; m_prev = 0; m_bad = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            m_seen[i] = 0; m_dig[i] = 4'h0; m_dot[i] = 1'b0;
        end
        m_data = 16'h0; m_dots = 4'h0;
        m_fv = 0; m_stable = 0; m_se = 0; m_qe = 0; m_lost = 0;
        m_last_data = 16'h0; m_last_dot = 4'h0; m_last_ok = 0; m_run = 0;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 4; i++) m_seen[i] = 0;
    endtask

    task automatic emit(input logic [15:0] f, input logic [3:0] fd);
        m_data = f; m_dots = fd; m_fv = 1; m_stable = 1;
        frames++;
        $display("[TB] publish #%0d data=%h dot=%b t=%0t", frames, f, fd, $time);
    endtask

    task automatic publish();
        logic [15:0] f;
        logic [3:0]  fd;
        f  = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        fd = {m_dot[3], m_dot[2], m_dot[1], m_dot[0]};
`ifdef SEG_SCAN_STABLE_FILTER_EN
        if (m_last_ok && f == m_last_data && fd == m_last_dot) begin
            int n;
            n = m_run + 1;
            if (n == STABLE_FRAMES) emit(f, fd);
            m_run = (n > 15) ? 15 : n;
        end else begin
            m_run = 1; m_last_data = f; m_last_dot = fd; m_last_ok = 1;
            m_stable = 0;
            if (STABLE_FRAMES == 1) emit(f, fd);
        end
`else
        emit(f, fd);
`endif
    endtask

    task automatic take(input int k, input int n, input logic dp);
        if (n < 0) begin
            m_se = 1; m_bad = 1; n = 0;
        end
        m_dig[k] = 4'(n); m_dot[k] = dp; m_seen[k] = 1; m_prev = k;
    endtask

    // One scan-clock step on the sample captured at the previous edge (normalised, active-high)
    task automatic model_step(input logic [3:0] w, input logic [7:0] d);
        int  k, n;
        bit  progress, all_seen;
        m_fv = 0; m_se = 0; m_qe = 0;
        k = -1; n = -1;
        if ($countones(w) == 1)
            for (int i = 0; i < 4; i++) if (w[i]) k = i;
        for (int i = 0; i < 16; i++) if (d[6:0] == seg_tab[i]) n = i;
        if (m_hunt) begin
            if (k >= 0) begin
                clear_seen(); m_bad = 0; m_lost = 0; m_hunt = 0; m_cnt = 0;
                take(k, n, d[7]);
            end
        end else begin
            progress = (k >= 0) && (!m_seen[k] || k != m_prev);
            if (!progress && m_cnt + 1 >= TIMEOUT) begin
                m_lost = 1; m_stable = 0; m_hunt = 1; clear_seen(); m_bad = 0; m_cnt = 0;
            end else if (k < 0) begin
                m_cnt++;
            end else if (!m_seen[k]) begin
                take(k, n, d[7]);
                m_cnt = 0;
                all_seen = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
                if (all_seen) begin
                    clear_seen();
                    if (!m_bad) publish();
                    m_bad = 0;
                end
            end else if (k == m_prev) begin
                take(k, n, d[7]);
                m_cnt++;
            end else begin
                m_qe = 1; clear_seen(); m_bad = 0; m_cnt = 0;
                take(k, n, d[7]);
            end
        end
    endtask

    task automatic cycle(input logic r, input logic [3:0] w, input logic [7:0] d);
        rst = r; sm_wei = w; sm_duan = d;
        @(posedge clk);
        if (r) model_reset();
        else   model_step(pw, pd);
        pw = r ? 4'h0 : ~w;
        pd = r ? 8'h00 : ~d;
        #1;
        check("data_out",    data_out,    m_data);
        check("dot_out",     {12'h0, dot_out}, {12'h0, m_dots});
        check("frame_valid", {15'h0, frame_valid}, {15'h0, m_fv});
        check("stable",      {15'h0, stable},      {15'h0, m_stable});
        check("seg_err",     {15'h0, seg_err},     {15'h0, m_se});
        check("seq_err",     {15'h0, seq_err},     {15'h0, m_qe});
        check("scan_lost",   {15'h0, scan_lost},   {15'h0, m_lost});
    endtask

    task automatic send(input int k, input int n, input bit dp, input bit bad);
        logic [3:0] w;
        logic [7:0] s;
        w = 4'b0001 << k;
        s = {dp, bad ? 7'h00 : seg_tab[n]};
        cycle(1'b0, ~w, ~s);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 4'hF, 8'hFF);
    endtask

    task automatic frame(input logic [15:0] v, input logic [3:0] dp);
        for (int k = 3; k >= 0; k--) send(k, int'(v[k*4 +: 4]), dp[k], 1'b0);
    endtask

    initial begin
        logic [15:0] val;
        logic [3:0]  dps;
        logic [3:0]  junk;
        pw = 4'h0; pd = 8'h00;
        model_reset();
        repeat (3) cycle(1'b1, 4'hF, 8'hFF);

        // Basic decode and repeated identical frames
        repeat (4) begin
            frame(16'hA244, 4'b1000);
            idle(2);
        end
        frame(16'h9044, 4'b0000);
        idle(2);

        // Revisit 3,2,3 then complete the restarted frame
        send(3, 1, 0, 0); send(2, 2, 0, 0); send(3, 5, 1, 0);
        send(2, 6, 0, 0); send(1, 7, 0, 0); send(0, 8, 0, 0);
        idle(2);

        // Undecodable digit 1 discards the frame
        send(3, 1, 0, 0); send(2, 2, 0, 0); send(1, 0, 0, 1); send(0, 3, 0, 0);
        idle(2);

        // Scan lost with no digits active, then recovery
        send(3, 4, 0, 0); send(2, 4, 0, 0);
        idle(TIMEOUT + 2);
        frame(16'h1234, 4'b0101);
        idle(2);

        // Reset mid-frame
        send(3, 15, 0, 0); send(2, 14, 0, 0);
        cycle(1'b1, 4'hF, 8'hFF);
        frame(16'hBEEF, 4'b0011);
        idle(2);

        // Randomised scans with injected faults
        val = 16'h0; dps = 4'h0;
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 1) == 0) begin
                val = 16'($urandom);
                dps = 4'($urandom);
            end
            for (int k = 3; k >= 0; k--) begin
                if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       junk = 4'hF;
                        1:       junk = 4'h0;
                        default: junk = 4'b0011;
                    endcase
                    repeat ($urandom_range(1, 3)) cycle(1'b0, junk, 8'($urandom));
                end
                send(k, int'(val[k*4 +: 4]), dps[k], $urandom_range(0, 24) == 0);
                if ($urandom_range(0, 5) == 0) send(k, int'(val[k*4 +: 4]), dps[k], $urandom_range(0, 9) == 0);
                if (k <= 1 && $urandom_range(0, 19) == 0) send(3, int'(val[15:12]), dps[3], 1'b0);
            end
            if ($urandom_range(0, 29) == 0) idle(TIMEOUT + 3);
            if ($urandom_range(0, 39) == 0) cycle(1'b1, 4'hF, 8'hFF);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
